// File: rtl/tone_player.sv
// Square-wave tone player: accepts (half-period, duration) notes and drives a speaker
// output for the requested number of milliseconds, with a live-programmable ms prescaler.
module tone_player #(
    parameter int unsigned PERIOD_W = 12,
    parameter int unsigned DUR_W    = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         ticks_per_milli,
    input  logic                note_valid,
    input  logic [PERIOD_W-1:0] note_period,
    input  logic [DUR_W-1:0]    note_dur_ms,
    input  logic                stop,
    output logic                note_ready,
    output logic                busy,
    output logic                done,
    output logic                ms_tick,
    output logic                sound
);

    typedef enum logic {
        StIdle,
        StPlay
    } state_e;

    localparam logic [PERIOD_W-1:0] PeriodOne = PERIOD_W'(1);
    localparam logic [DUR_W-1:0]    DurOne    = DUR_W'(1);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [15:0]         presc_q, presc_d;
    logic [DUR_W-1:0]    remain_q, remain_d;
    logic                sound_q, sound_d;
    logic                done_q, done_d;
    logic                tick_q, tick_d;

    logic [15:0] tick_lim;
    logic        accept;

    always_comb begin
        // A programmed value of 0 behaves as 1 tick per millisecond.
        tick_lim = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
        accept   = (state_q == StIdle) && note_valid && !stop;

        state_d  = state_q;
        period_d = period_q;
        half_d   = half_q;
        presc_d  = presc_q;
        remain_d = remain_q;
        sound_d  = sound_q;
        done_d   = 1'b0;
        tick_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                sound_d = 1'b0;
                if (accept) begin
                    if (note_dur_ms == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = StPlay;
                        period_d = note_period;
                        remain_d = note_dur_ms;
                        presc_d  = 16'd0;
                        half_d   = '0;
                        tick_d   = (tick_lim == 16'd0);
                    end
                end
            end
            StPlay: begin
                if (stop || (tick_q && remain_q == DurOne)) begin
                    state_d  = StIdle;
                    done_d   = !stop;
                    sound_d  = 1'b0;
                    period_d = '0;
                    half_d   = '0;
                    presc_d  = 16'd0;
                    remain_d = '0;
                end else begin
                    if (tick_q) begin
                        presc_d  = 16'd0;
                        remain_d = remain_q - DurOne;
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                    // tick is registered one cycle ahead so ms_tick is glitch-free yet on time.
                    tick_d = (presc_d >= tick_lim);

                    if (period_q == '0) begin
                        sound_d = 1'b0;
                    end else if (half_q == period_q - PeriodOne) begin
                        sound_d = !sound_q;
                        half_d  = '0;
                    end else begin
                        half_d = half_q + PeriodOne;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            period_q <= '0;
            half_q   <= '0;
            presc_q  <= 16'd0;
            remain_q <= '0;
            sound_q  <= 1'b0;
            done_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            half_q   <= half_d;
            presc_q  <= presc_d;
            remain_q <= remain_d;
            sound_q  <= sound_d;
            done_q   <= done_d;
            tick_q   <= tick_d;
        end
    end

    assign busy       = (state_q == StPlay);
    assign note_ready = (state_q == StIdle);
    assign done       = done_q;
    assign ms_tick    = tick_q;
    assign sound      = sound_q;

endmodule

// File: tb/tb_tone_player.sv
// Directed self-checking bench for tone_player; inputs change and outputs are
// sampled on the falling clock edge.
module tb_tone_player;

    localparam int unsigned PERIOD_W = 12;
    localparam int unsigned DUR_W    = 10;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [15:0]         ticks_per_milli;
    logic                note_valid;
    logic [PERIOD_W-1:0] note_period;
    logic [DUR_W-1:0]    note_dur_ms;
    logic                stop;
    logic                note_ready;
    logic                busy;
    logic                done;
    logic                ms_tick;
    logic                sound;

    int n_checks = 0;
    int n_errors = 0;

    tone_player #(
        .PERIOD_W(PERIOD_W),
        .DUR_W   (DUR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ticks_per_milli(ticks_per_milli),
        .note_valid     (note_valid),
        .note_period    (note_period),
        .note_dur_ms    (note_dur_ms),
        .stop           (stop),
        .note_ready     (note_ready),
        .busy           (busy),
        .done           (done),
        .ms_tick        (ms_tick),
        .sound          (sound)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input int p, input int d);
        note_valid  = v;
        note_period = PERIOD_W'(p);
        note_dur_ms = DUR_W'(d);
    endtask

    task automatic check_all(input string tag, input logic b, input logic dn, input logic mt,
                             input logic snd);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".ready"}, 32'(note_ready), 32'(!b));
        check({tag, ".done"}, 32'(done), 32'(dn));
        check({tag, ".ms_tick"}, 32'(ms_tick), 32'(mt));
        check({tag, ".sound"}, 32'(sound), 32'(snd));
    endtask

    initial begin
        rst_n           = 1'b0;
        stop            = 1'b0;
        ticks_per_milli = 16'd4;
        offer(1'b0, 0, 0);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // T=4, P=2, D=3
        offer(1'b1, 2, 3);
        step();
        offer(1'b0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            check_all($sformatf("n1.c%0d", i), 1'b1, 1'b0, (i % 4) == 0, ((i - 1) / 2) % 2 == 1);
            step();
        end
        check_all("n1.end", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("n1.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Rest: T=5, P=0, D=2
        ticks_per_milli = 16'd5;
        offer(1'b1, 0, 2);
        step();
        offer(1'b0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            check_all($sformatf("rest.c%0d", i), 1'b1, 1'b0, (i % 5) == 0, 1'b0);
            step();
        end
        check_all("rest.end", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("rest.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero duration
        offer(1'b1, 7, 0);
        step();
        offer(1'b0, 0, 0);
        check_all("d0.pulse", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("d0.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back with note_valid held, T=2
        ticks_per_milli = 16'd2;
        offer(1'b1, 1, 1);
        step();
        offer(1'b1, 3, 2);
        check_all("b2b.a1", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check_all("b2b.a2", 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        check_all("b2b.gap", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        offer(1'b0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            check_all($sformatf("b2b.b%0d", i), 1'b1, 1'b0, (i % 2) == 0, i == 4);
            step();
        end
        check_all("b2b.end", 1'b0, 1'b1, 1'b0, 1'b0);
        step();

        // Stop 5 cycles into T=4, P=2, D=3
        ticks_per_milli = 16'd4;
        offer(1'b1, 2, 3);
        step();
        offer(1'b0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            check_all($sformatf("stp.c%0d", i), 1'b1, 1'b0, (i % 4) == 0, ((i - 1) / 2) % 2 == 1);
            if (i < 5) step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_all("stp.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("stp.nodone", 1'b0, 1'b0, 1'b0, 1'b0);

        // Stop in IDLE blocks acceptance
        offer(1'b1, 2, 3);
        stop = 1'b1;
        step();
        check("stpidle.busy", 32'(busy), 32'd0);
        stop = 1'b0;
        step();
        offer(1'b0, 0, 0);
        check("stpidle.accept", 32'(busy), 32'd1);
        step();
        step();
        check("rst.pre_sound", 32'(sound), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst.mid", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check_all("rst.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // ticks_per_milli = 0 acts as T=1
        ticks_per_milli = 16'd0;
        offer(1'b1, 0, 3);
        step();
        offer(1'b0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            check_all($sformatf("t0.c%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
            step();
        end
        check_all("t0.end", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("t0.after", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
